// File: rtl/led_pattern_driver.sv
// Multi-channel LED pattern driver: off/on/blink/PWM per channel from a shared prescaler and PWM counter.
// Optional breathe mode (mode 4) is compiled in when LED_BREATHE_EN is defined.
module led_pattern_driver #(
  parameter int NUM_LEDS       = 8,
  parameter int DIV_WIDTH      = 22,
  parameter int PWM_WIDTH      = 8,
  parameter int LED_ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [3:0]           cfg_chan,
  input  logic [2:0]           cfg_mode,
  input  logic [PWM_WIDTH-1:0] cfg_duty,
  output logic                 tick,
  output logic [NUM_LEDS-1:0]  led
);

  localparam logic [2:0] MODE_ON    = 3'd1;
  localparam logic [2:0] MODE_BLINK = 3'd2;
  localparam logic [2:0] MODE_PWM   = 3'd3;
`ifdef LED_BREATHE_EN
  localparam logic [2:0]           MODE_BREATHE = 3'd4;
  localparam logic [PWM_WIDTH-1:0] PWM_ONE      = PWM_WIDTH'(1);
  localparam logic [PWM_WIDTH-1:0] PWM_TOP      = {PWM_WIDTH{1'b1}};
  localparam logic [PWM_WIDTH-1:0] PWM_TOP_M1   = PWM_TOP - PWM_ONE;
`endif
  localparam logic [NUM_LEDS-1:0] LED_INV = {NUM_LEDS{LED_ACTIVE_LOW != 0}};

  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic [PWM_WIDTH-1:0] r_pwm_cnt;
  logic                 r_cfg_ready;
  logic [NUM_LEDS-1:0]  r_led;
  logic [NUM_LEDS-1:0]  w_led_val;
  logic                 w_tick;
  logic                 w_accept;

  assign w_tick    = &r_div_cnt;
  assign w_accept  = cfg_valid && r_cfg_ready;
  assign tick      = w_tick;
  assign cfg_ready = r_cfg_ready;
  assign led       = r_led;

  // Shared timebase: every channel derives its pattern from these two counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div_cnt   <= '0;
      r_pwm_cnt   <= '0;
      r_cfg_ready <= 1'b0;
    end else begin
      r_div_cnt   <= r_div_cnt + 1'b1;
      r_pwm_cnt   <= r_pwm_cnt + 1'b1;
      r_cfg_ready <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    logic [2:0]           r_mode;
    logic [PWM_WIDTH-1:0] r_duty;
    logic                 r_phase;
    logic                 w_wr;
    logic                 w_val;

    // Out-of-range channel indices match no channel, so such writes are dropped
    assign w_wr = w_accept && (cfg_chan == 4'(i));

    // A write in a tick cycle clears phase rather than toggling it
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_mode  <= '0;
        r_duty  <= '0;
        r_phase <= 1'b0;
      end else if (w_wr) begin
        r_mode  <= cfg_mode;
        r_duty  <= cfg_duty;
        r_phase <= 1'b0;
      end else if (w_tick) begin
        r_phase <= ~r_phase;
      end
    end

`ifdef LED_BREATHE_EN
    logic [PWM_WIDTH-1:0] r_level;
    logic                 r_dir;

    // Triangle ramp: direction flips on the step that lands on either end
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_level <= '0;
        r_dir   <= 1'b0;
      end else if (w_wr) begin
        r_level <= '0;
        r_dir   <= 1'b0;
      end else if (w_tick && (r_mode == MODE_BREATHE)) begin
        if (!r_dir) begin
          r_level <= r_level + PWM_ONE;
          if (r_level == PWM_TOP_M1) r_dir <= 1'b1;
        end else begin
          r_level <= r_level - PWM_ONE;
          if (r_level == PWM_ONE) r_dir <= 1'b0;
        end
      end
    end
`endif

    always_comb begin
      w_val = 1'b0;
      case (r_mode)
        MODE_ON:      w_val = 1'b1;
        MODE_BLINK:   w_val = r_phase;
        MODE_PWM:     w_val = (r_pwm_cnt < r_duty);
`ifdef LED_BREATHE_EN
        MODE_BREATHE: w_val = (r_pwm_cnt < r_level);
`endif
        default:      w_val = 1'b0;
      endcase
    end

    assign w_led_val[i] = w_val;
  end

  // Output register stage; polarity applied here so reset drives the inactive level
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_led <= LED_INV;
    end else begin
      r_led <= w_led_val ^ LED_INV;
    end
  end

endmodule
